// File: rtl/forbid_mon_pkg.sv
// Shared types and default sizes for the forbidden-sequence monitor.
//   fmon_state_t : monitor FSM encoding (ARMED / FLAGGED / ACKED)
//   DLY_MAX      : largest supported p->q distance in cycles
//   CNT_W_DEF    : default width of the violation counter
//   TS_W_DEF     : default width of the cycle timestamp
package forbid_mon_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    FLAGGED = 2'd1,
    ACKED   = 2'd2
  } fmon_state_t;

  localparam int DLY_MAX   = 8;
  localparam int CNT_W_DEF = 8;
  localparam int TS_W_DEF  = 16;

endpackage

// File: rtl/p_delay_line.sv
// DEPTH-deep history of the antecedent signal.
//   clk      : clock
//   rst_n    : asynchronous active-low reset (history cleared)
//   en       : shift enable, one new sample per enabled cycle
//   flush    : synchronous clear, takes priority over shifting
//   din      : sample shifted in at bit 0
//   hist_msb : sample taken exactly DEPTH enabled cycles ago
module p_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic flush,
  input  logic din,
  output logic hist_msb
);

  logic [DEPTH-1:0] hist_r;
  logic [DEPTH:0]   shifted_s;

  // Extending by one bit keeps the shift legal even when DEPTH is 1.
  assign shifted_s = {hist_r, din};
  assign hist_msb  = hist_r[DEPTH-1];

  // History shift register with flush priority over shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r <= '0;
    end else if (flush) begin
      hist_r <= '0;
    end else if (en) begin
      hist_r <= shifted_s[DEPTH-1:0];
    end else begin
      hist_r <= hist_r;
    end
  end

endmodule

// File: rtl/forbid_seq_monitor.sv
// Run-time checker for "p followed DLY enabled cycles later by q".
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : monitor enable (blocks detection, flushes p history, freezes ts)
//   clr        : synchronous clear of all status, beats every other event
//   p, q       : antecedent / consequent
//   irq_ack    : single-cycle interrupt acknowledge
//   viol       : one-cycle pulse, one cycle after each detection
//   err_sticky : set on first violation, held until clr/reset
//   irq        : interrupt request, high while FSM is FLAGGED
//   viol_cnt   : saturating violation count
//   first_ts   : timestamp of first violation since clr/reset
//   state      : FSM state for debug
// DLY must lie in 1..DLY_MAX.
module forbid_seq_monitor
  import forbid_mon_pkg::*;
#(
  parameter int DLY   = 1,
  parameter int CNT_W = CNT_W_DEF,
  parameter int TS_W  = TS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             p,
  input  logic             q,
  input  logic             irq_ack,
  output logic             viol,
  output logic             err_sticky,
  output logic             irq,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [TS_W-1:0]  first_ts,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  fmon_state_t      state_r, state_nxt_s;
  logic [TS_W-1:0]  ts_r;
  logic             hist_msb_s;
  logic             detect_s;
  logic             viol_r, viol_nxt_s;
  logic             err_r, err_nxt_s;
  logic             irq_r, irq_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [TS_W-1:0]  first_ts_r, first_ts_nxt_s;

  // Disabled or cleared cycles flush history so a stale p never pairs with a later q.
  p_delay_line #(.DEPTH(DLY)) u_p_delay_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .flush    (clr | ~en),
    .din      (p),
    .hist_msb (hist_msb_s)
  );

  assign detect_s = en & q & hist_msb_s;

  // Free-running timestamp, frozen while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_r <= '0;
    end else if (clr) begin
      ts_r <= '0;
    end else if (en) begin
      ts_r <= ts_r + TS_W'(1'b1);
    end else begin
      ts_r <= ts_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARMED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: a detect always wins over an acknowledge in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = ARMED;
    end else begin
      case (state_r)
        ARMED: begin
          if (detect_s) state_nxt_s = FLAGGED;
          else          state_nxt_s = ARMED;
        end
        FLAGGED: begin
          if (detect_s)     state_nxt_s = FLAGGED;
          else if (irq_ack) state_nxt_s = ACKED;
          else              state_nxt_s = FLAGGED;
        end
        ACKED: begin
          if (detect_s) state_nxt_s = FLAGGED;
          else          state_nxt_s = ACKED;
        end
        default: state_nxt_s = ARMED;
      endcase
    end
  end

  // Next values of the registered outputs; clr discards a coincident detect.
  always_comb begin
    viol_nxt_s     = 1'b0;
    err_nxt_s      = err_r;
    cnt_nxt_s      = cnt_r;
    first_ts_nxt_s = first_ts_r;
    irq_nxt_s      = 1'b0;
    if (clr) begin
      viol_nxt_s     = 1'b0;
      err_nxt_s      = 1'b0;
      cnt_nxt_s      = '0;
      first_ts_nxt_s = '0;
    end else if (detect_s) begin
      viol_nxt_s = 1'b1;
      err_nxt_s  = 1'b1;
      if (cnt_r != CNT_MAX) cnt_nxt_s = cnt_r + CNT_W'(1'b1);
      else                  cnt_nxt_s = cnt_r;
      // Only the first violation since clr is timestamped.
      if (state_r == ARMED) first_ts_nxt_s = ts_r;
      else                  first_ts_nxt_s = first_ts_r;
    end else begin
      viol_nxt_s = 1'b0;
    end
    // irq is decoded from the next state so it lines up with the state output.
    if (state_nxt_s == FLAGGED) irq_nxt_s = 1'b1;
    else                        irq_nxt_s = 1'b0;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_r     <= 1'b0;
      err_r      <= 1'b0;
      irq_r      <= 1'b0;
      cnt_r      <= '0;
      first_ts_r <= '0;
    end else begin
      viol_r     <= viol_nxt_s;
      err_r      <= err_nxt_s;
      irq_r      <= irq_nxt_s;
      cnt_r      <= cnt_nxt_s;
      first_ts_r <= first_ts_nxt_s;
    end
  end

  assign viol       = viol_r;
  assign err_sticky = err_r;
  assign irq        = irq_r;
  assign viol_cnt   = cnt_r;
  assign first_ts   = first_ts_r;
  assign state      = state_r;

endmodule

// File: tb/tb_forbid_seq_monitor.sv
// Directed bench for forbid_seq_monitor. Three instances share one stimulus:
//   a: DLY=1, CNT_W=8   b: DLY=1, CNT_W=2   c: DLY=3, CNT_W=8
// Inputs change #1 after a rising edge; "cycle k" is the interval in which the
// k-th set of inputs is applied, and registered results are sampled #1 after
// the edge that closes it.
module tb_forbid_seq_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, clr = 1'b0, p = 1'b0, q = 1'b0, irq_ack = 1'b0;

  logic        a_viol, a_err, a_irq;
  logic [7:0]  a_cnt;
  logic [15:0] a_ts;
  logic [1:0]  a_state;
  logic        b_viol, b_err, b_irq;
  logic [1:0]  b_cnt;
  logic [15:0] b_ts;
  logic [1:0]  b_state;
  logic        c_viol, c_err, c_irq;
  logic [7:0]  c_cnt;
  logic [15:0] c_ts;
  logic [1:0]  c_state;

  int vectors = 0;
  int miscompares = 0;

  logic [19:0] p_tab, q_tab, v_tab;

  always #5 clk = ~clk;

  forbid_seq_monitor #(.DLY(1), .CNT_W(8), .TS_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .p(p), .q(q), .irq_ack(irq_ack),
    .viol(a_viol), .err_sticky(a_err), .irq(a_irq), .viol_cnt(a_cnt),
    .first_ts(a_ts), .state(a_state)
  );

  forbid_seq_monitor #(.DLY(1), .CNT_W(2), .TS_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .p(p), .q(q), .irq_ack(irq_ack),
    .viol(b_viol), .err_sticky(b_err), .irq(b_irq), .viol_cnt(b_cnt),
    .first_ts(b_ts), .state(b_state)
  );

  forbid_seq_monitor #(.DLY(3), .CNT_W(8), .TS_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .p(p), .q(q), .irq_ack(irq_ack),
    .viol(c_viol), .err_sticky(c_err), .irq(c_irq), .viol_cnt(c_cnt),
    .first_ts(c_ts), .state(c_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; p = 1'b0; q = 1'b0; irq_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    do_reset();
    chk("rst_viol",  {31'd0, a_viol}, 32'd0);
    chk("rst_err",   {31'd0, a_err},  32'd0);
    chk("rst_irq",   {31'd0, a_irq},  32'd0);
    chk("rst_cnt",   {24'd0, a_cnt},  32'd0);
    chk("rst_ts",    {16'd0, a_ts},   32'd0);
    chk("rst_state", {30'd0, a_state}, 32'd0);

    // Basic violation, DLY=1: p at cycle 0, p&q at cycle 1.
    en = 1'b1; p = 1'b1; q = 1'b0; tick();            // -> cycle 1
    p = 1'b1; q = 1'b1; tick();                        // -> cycle 2
    chk("c1_viol",  {31'd0, a_viol},  32'd1);
    chk("c1_cnt",   {24'd0, a_cnt},   32'd1);
    chk("c1_ts",    {16'd0, a_ts},    32'd1);
    chk("c1_err",   {31'd0, a_err},   32'd1);
    chk("c1_irq",   {31'd0, a_irq},   32'd1);
    chk("c1_state", {30'd0, a_state}, 32'd1);
    p = 1'b0; q = 1'b0; tick();                        // -> cycle 3
    chk("c1_pulse", {31'd0, a_viol},  32'd0);
    tick();                                            // -> cycle 4
    irq_ack = 1'b1; tick();                            // -> cycle 5
    irq_ack = 1'b0;
    chk("ack_irq",   {31'd0, a_irq},   32'd0);
    chk("ack_state", {30'd0, a_state}, 32'd2);
    chk("ack_err",   {31'd0, a_err},   32'd1);
    tick();                                            // -> cycle 6
    p = 1'b1; tick();                                  // -> cycle 7
    p = 1'b0; q = 1'b1; tick();                        // -> cycle 8
    chk("reflag_state", {30'd0, a_state}, 32'd1);
    chk("reflag_irq",   {31'd0, a_irq},   32'd1);
    chk("reflag_ts",    {16'd0, a_ts},    32'd1);
    chk("reflag_cnt",   {24'd0, a_cnt},   32'd2);
    p = 1'b1; q = 1'b0; tick();                        // -> cycle 9
    p = 1'b0; q = 1'b1; irq_ack = 1'b1; tick();        // -> cycle 10
    irq_ack = 1'b0; q = 1'b0;
    chk("ackdet_irq",   {31'd0, a_irq},   32'd1);
    chk("ackdet_state", {30'd0, a_state}, 32'd1);
    chk("ackdet_cnt",   {24'd0, a_cnt},   32'd3);

    // clr coincident with a detect (cycle 11), then a fresh violation.
    p = 1'b1; tick();                                  // -> cycle 11
    p = 1'b0; q = 1'b1; clr = 1'b1; tick();            // -> cycle 12
    clr = 1'b0; q = 1'b0;
    chk("clrdet_viol",  {31'd0, a_viol},  32'd0);
    chk("clrdet_cnt",   {24'd0, a_cnt},   32'd0);
    chk("clrdet_ts",    {16'd0, a_ts},    32'd0);
    chk("clrdet_err",   {31'd0, a_err},   32'd0);
    chk("clrdet_irq",   {31'd0, a_irq},   32'd0);
    chk("clrdet_state", {30'd0, a_state}, 32'd0);
    irq_ack = 1'b1; tick();                            // -> cycle 13, ack ignored in ARMED
    irq_ack = 1'b0;
    chk("ackarmed_state", {30'd0, a_state}, 32'd0);
    p = 1'b1; tick();                                  // -> cycle 14 (ts=2)
    p = 1'b0; q = 1'b1; tick();                        // -> cycle 15
    q = 1'b0;
    chk("postclr_ts",    {16'd0, a_ts},    32'd2);
    chk("postclr_cnt",   {24'd0, a_cnt},   32'd1);
    chk("postclr_state", {30'd0, a_state}, 32'd1);
    clr = 1'b1; tick();                                // -> cycle 16, plain clr
    clr = 1'b0;
    chk("clr_cnt",   {24'd0, a_cnt},   32'd0);
    chk("clr_ts",    {16'd0, a_ts},    32'd0);
    chk("clr_err",   {31'd0, a_err},   32'd0);
    chk("clr_irq",   {31'd0, a_irq},   32'd0);
    chk("clr_state", {30'd0, a_state}, 32'd0);

    // Enable gating: ts 0 at cycle 16; p at 18, en=0 at 19, q at 20.
    tick();                                            // -> cycle 17
    tick();                                            // -> cycle 18
    p = 1'b1; tick();                                  // -> cycle 19
    p = 1'b0; en = 1'b0; tick();                       // -> cycle 20
    en = 1'b1; q = 1'b1; tick();                       // -> cycle 21
    q = 1'b0;
    chk("gate_viol",  {31'd0, a_viol},  32'd0);
    chk("gate_cnt",   {24'd0, a_cnt},   32'd0);
    chk("gate_state", {30'd0, a_state}, 32'd0);
    p = 1'b1; tick();                                  // -> cycle 22 (ts=5)
    p = 1'b0; q = 1'b1; tick();                        // -> cycle 23
    q = 1'b0;
    chk("gate_ts",  {16'd0, a_ts},  32'd5);
    chk("gate_cnt2", {24'd0, a_cnt}, 32'd1);
    en = 1'b0; tick();                                 // -> cycle 24
    chk("dis_state", {30'd0, a_state}, 32'd1);
    chk("dis_cnt",   {24'd0, a_cnt},   32'd1);
    chk("dis_ts",    {16'd0, a_ts},    32'd5);
    chk("dis_irq",   {31'd0, a_irq},   32'd1);

    // p and q held high for cycles 0..5; narrow counter saturates at 3.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      en = 1'b1; p = 1'b1; q = 1'b1; tick();
      chk("hold_viol", {31'd0, a_viol}, (k >= 1) ? 32'd1 : 32'd0);
    end
    p = 1'b0; q = 1'b0; tick();
    chk("hold_viol_end", {31'd0, a_viol}, 32'd0);
    chk("hold_cnt",      {24'd0, a_cnt},  32'd5);
    chk("hold_ts",       {16'd0, a_ts},   32'd1);
    chk("sat_cnt",       {30'd0, b_cnt},  32'd3);

    // DLY=3: p at 0,8,16; q at 2,4,11,19; only q at 11 and 19 complete a sequence.
    do_reset();
    p_tab = 20'h10101;
    q_tab = 20'h80814;
    v_tab = 20'h80800;
    for (int c = 0; c < 20; c++) begin
      en = 1'b1; p = p_tab[c]; q = q_tab[c]; tick();
      chk("dly3_viol", {31'd0, c_viol}, {31'd0, v_tab[c]});
    end
    p = 1'b0; q = 1'b0;
    chk("dly3_cnt",   {24'd0, c_cnt},   32'd2);
    chk("dly3_ts",    {16'd0, c_ts},    32'd11);
    chk("dly3_state", {30'd0, c_state}, 32'd1);
    chk("dly3_irq",   {31'd0, c_irq},   32'd1);

    // Asynchronous reset between edges while viol/irq/err are high.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_viol",  {31'd0, c_viol},  32'd0);
    chk("arst_err",   {31'd0, c_err},   32'd0);
    chk("arst_irq",   {31'd0, c_irq},   32'd0);
    chk("arst_cnt",   {24'd0, c_cnt},   32'd0);
    chk("arst_ts",    {16'd0, c_ts},    32'd0);
    chk("arst_state", {30'd0, c_state}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
